param_up_down_counter: RTL and testbench

Parametrised successor to the team's 8-bit four-mode up/down counter. Width, step size and upper limit are programmable, and overflow can either wrap or saturate. The block adds a clock prescaler, single-cycle carry/borrow pulses, a terminal-count flag and a load-range error pulse. It sits in the datapath wherever a bounded event or address counter is needed, driven by the same 2-bit mode select as the 8-bit counter.

---
 rtl/param_up_down_counter.sv | 109 ++++++++++
 tb/tb_param_up_down_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with programmable step and limit, wrap or saturate
// on overflow, clock prescaler, carry/borrow/terminal-count flags and load clamping.
module param_up_down_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [1:0]       s_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] step_in,
    input  logic [WIDTH-1:0] limit_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             tc_out,
    output logic             load_err_out
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_INC  = 2'b01,
        MODE_DEC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    mode_t            mode;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_n;
    logic             tick;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] cnt_n;
    logic             carry_n;
    logic             borrow_n;
    logic             tc_n;
    logic             lerr_n;

    assign mode = mode_t'(s_in);
    assign tick = (presc == PW'(PRESCALE - 1));
    assign sum  = {1'b0, data_out} + {1'b0, step_in};

    always_comb begin
        cnt_n    = data_out;
        presc_n  = '0;
        carry_n  = 1'b0;
        borrow_n = 1'b0;
        tc_n     = 1'b0;
        lerr_n   = 1'b0;
        case (mode)
            MODE_HOLD: ;
            MODE_LOAD: begin
                if (data_in <= limit_in) begin
                    cnt_n = data_in;
                end else begin
                    cnt_n  = limit_in;
                    lerr_n = 1'b1;
                end
            end
            MODE_INC: begin
                if (!tick) begin
                    presc_n = presc + 1'b1;
                end else if (step_in != '0) begin
                    // Zero step is excluded so a lowered limit alone never raises carry.
                    if (sum <= {1'b0, limit_in}) begin
                        cnt_n = sum[WIDTH-1:0];
                    end else begin
                        carry_n = 1'b1;
                        cnt_n   = (SATURATE != 0) ? limit_in : '0;
                    end
                end
                tc_n = (cnt_n == limit_in);
            end
            MODE_DEC: begin
                if (!tick) begin
                    presc_n = presc + 1'b1;
                end else if (data_out >= step_in) begin
                    cnt_n = data_out - step_in;
                end else begin
                    borrow_n = 1'b1;
                    cnt_n    = (SATURATE != 0) ? '0 : limit_in;
                end
                tc_n = (cnt_n == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            data_out     <= '0;
            presc        <= '0;
            carry_out    <= 1'b0;
            borrow_out   <= 1'b0;
            tc_out       <= 1'b0;
            load_err_out <= 1'b0;
        end else begin
            data_out     <= cnt_n;
            presc        <= presc_n;
            carry_out    <= carry_n;
            borrow_out   <= borrow_n;
            tc_out       <= tc_n;
            load_err_out <= lerr_n;
        end
    end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench: three counter variants (wrap, saturate, prescale-by-4) share stimulus;
// each check compares one output against a hand-computed value.
module tb_param_up_down_counter;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [1:0] s_in;
    logic [7:0] data_in;
    logic [7:0] step_in;
    logic [7:0] limit_in;

    logic [7:0] w_data, s_data, p_data;
    logic       w_carry, w_borrow, w_tc, w_lerr;
    logic       s_carry, s_borrow, s_tc, s_lerr;
    logic       p_carry, p_borrow, p_tc, p_lerr;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    localparam logic [1:0] HOLD = 2'b00, INC = 2'b01, DEC = 2'b10, LOAD = 2'b11;

    always #5 clk_in = ~clk_in;

    param_up_down_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk_in(clk_in), .reset_in(reset_in), .s_in(s_in), .data_in(data_in),
        .step_in(step_in), .limit_in(limit_in), .data_out(w_data),
        .carry_out(w_carry), .borrow_out(w_borrow), .tc_out(w_tc), .load_err_out(w_lerr)
    );

    param_up_down_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk_in(clk_in), .reset_in(reset_in), .s_in(s_in), .data_in(data_in),
        .step_in(step_in), .limit_in(limit_in), .data_out(s_data),
        .carry_out(s_carry), .borrow_out(s_borrow), .tc_out(s_tc), .load_err_out(s_lerr)
    );

    param_up_down_counter #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) u_pre (
        .clk_in(clk_in), .reset_in(reset_in), .s_in(s_in), .data_in(data_in),
        .step_in(step_in), .limit_in(limit_in), .data_out(p_data),
        .carry_out(p_carry), .borrow_out(p_borrow), .tc_out(p_tc), .load_err_out(p_lerr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge with the current inputs, then sample just after it.
    task automatic cyc(input logic [1:0] mode, input logic [7:0] d);
        s_in    = mode;
        data_in = d;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        reset_in = 1'b1;
        s_in     = HOLD;
        data_in  = '0;
        step_in  = 8'd1;
        limit_in = 8'd255;
        cyc(HOLD, 0);
        chk("rst_data", w_data, 0);
        chk("rst_flags", {w_carry, w_borrow, w_tc, w_lerr}, 0);
        chk("rst_pre_data", p_data, 0);
        reset_in = 1'b0;

        // Reset while counting
        cyc(LOAD, 77);
        chk("load77", w_data, 77);
        reset_in = 1'b1;
        cyc(INC, 0);
        chk("rst_mid_data", w_data, 0);
        chk("rst_mid_flags", {w_carry, w_borrow, w_tc, w_lerr}, 0);
        reset_in = 1'b0;
        cyc(INC, 0);
        chk("after_rst_inc", w_data, 1);

        // Load and clamp
        limit_in = 8'd200;
        cyc(LOAD, 33);
        chk("load33", w_data, 33);
        chk("load33_err", w_lerr, 0);
        cyc(LOAD, 245);
        chk("clamp_data", w_data, 200);
        chk("clamp_err", w_lerr, 1);
        chk("load_tc", w_tc, 0);
        cyc(HOLD, 0);
        chk("clamp_err_drop", w_lerr, 0);
        chk("hold_data", w_data, 200);

        // Wrap increment
        limit_in = 8'd255;
        step_in  = 8'd1;
        cyc(LOAD, 254);
        chk("load254", w_data, 254);
        cyc(INC, 0);
        chk("inc255", w_data, 255);
        chk("inc255_tc", w_tc, 1);
        chk("inc255_carry", w_carry, 0);
        cyc(INC, 0);
        chk("wrap0", w_data, 0);
        chk("wrap0_carry", w_carry, 1);
        chk("wrap0_tc", w_tc, 0);
        cyc(INC, 0);
        chk("wrap1", w_data, 1);
        chk("wrap1_carry", w_carry, 0);

        // Saturate decrement (wrap instance checked alongside)
        step_in = 8'd3;
        cyc(LOAD, 4);
        chk("sat_load4", s_data, 4);
        cyc(DEC, 0);
        chk("sat_dec1", s_data, 1);
        chk("sat_dec1_borrow", s_borrow, 0);
        cyc(DEC, 0);
        chk("sat_dec0", s_data, 0);
        chk("sat_dec0_borrow", s_borrow, 1);
        chk("sat_dec0_tc", s_tc, 1);
        chk("wrap_dec_data", w_data, 255);
        chk("wrap_dec_borrow", w_borrow, 1);
        cyc(DEC, 0);
        chk("sat_pin0", s_data, 0);
        chk("sat_pin0_borrow", s_borrow, 1);

        // Saturate increment pinned at limit
        step_in = 8'd10;
        cyc(LOAD, 250);
        cyc(INC, 0);
        chk("sat_inc_pin", s_data, 255);
        chk("sat_inc_carry", s_carry, 1);
        cyc(INC, 0);
        chk("sat_inc_pin2", s_data, 255);
        chk("sat_inc_carry2", s_carry, 1);

        // Prescale by 4
        step_in = 8'd2;
        cyc(LOAD, 10);
        chk("pre_load", p_data, 10);
        for (int i = 1; i <= 8; i++) begin
            cyc(INC, 0);
            chk($sformatf("pre_edge%0d", i), p_data, (i < 4) ? 10 : (i < 8) ? 12 : 14);
        end
        cyc(HOLD, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(INC, 0);
            chk($sformatf("pre_restart%0d", i), p_data, (i < 4) ? 14 : 16);
        end
        cyc(INC, 0);
        cyc(INC, 0);
        cyc(DEC, 0);
        chk("pre_switch3", p_data, 16);
        cyc(DEC, 0);
        chk("pre_switch4", p_data, 14);

        // Hold, then limit lowered below count
        limit_in = 8'd255;
        cyc(LOAD, 43);
        cyc(INC, 0);
        chk("count45", w_data, 45);
        for (int i = 0; i < 10; i++) cyc(HOLD, 0);
        chk("hold45", w_data, 45);
        chk("hold_tc", w_tc, 0);
        limit_in = 8'd40;
        cyc(INC, 0);
        chk("low_limit_data", w_data, 0);
        chk("low_limit_carry", w_carry, 1);

        // Zero step: no change, no pulse
        limit_in = 8'd255;
        cyc(LOAD, 5);
        step_in = 8'd0;
        limit_in = 8'd3;
        cyc(INC, 0);
        chk("step0_data", w_data, 5);
        chk("step0_carry", w_carry, 0);
        cyc(DEC, 0);
        chk("step0_dec", w_data, 5);
        chk("step0_borrow", w_borrow, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
